// File: rtl/word_tx_serializer.sv
// Word-to-byte serializer: queues 32-bit words in a small FIFO and hands them
// to a UART transmitter one byte at a time, least-significant byte first.
module word_tx_serializer #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     word_valid,
   input  logic [31:0]              word_data,
   output logic                     word_ready,
   output logic                     TX_enable,
   output logic [7:0]               TX_data,
   input  logic                     tx_busy,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     busy
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SEND,
      WAIT_ACK,
      WAIT_DONE
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [31:0]     r_mem [DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [AW:0]     r_count;
   logic [31:0]     r_shift;
   logic [1:0]      r_idx;
   logic [7:0]      r_tx_hold;
   logic [7:0]      w_byte;
   logic            w_push;
   logic            w_pop;

   assign word_ready = (r_count < L_FULL);
   assign w_push     = word_valid && word_ready;
   assign w_pop      = (r_state == LOAD);
   assign fifo_count = r_count;
   assign busy       = (r_state != IDLE) || (r_count != '0);

   always_ff @(posedge clk) begin
      if (!rst && w_push) begin
         r_mem[r_wr_ptr] <= word_data;
      end
   end

   // Push and pop may coincide in LOAD; the count then nets to zero change.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_comb begin
      w_byte = r_shift[7:0];
      case (r_idx)
         2'd0: w_byte = r_shift[7:0];
         2'd1: w_byte = r_shift[15:8];
         2'd2: w_byte = r_shift[23:16];
         2'd3: w_byte = r_shift[31:24];
         default: w_byte = r_shift[7:0];
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_idx     <= '0;
         r_shift   <= '0;
         r_tx_hold <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            LOAD: begin
               r_shift <= r_mem[r_rd_ptr];
               r_idx   <= '0;
            end
            SEND: r_tx_hold <= w_byte;
            WAIT_DONE: begin
               if (!tx_busy && (r_idx != 2'd3)) begin
                  r_idx <= r_idx + 2'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // TX_data shows the live byte during SEND and the last sent byte otherwise.
   always_comb begin
      w_next    = r_state;
      TX_enable = 1'b0;
      TX_data   = r_tx_hold;
      case (r_state)
         IDLE: begin
            if (r_count != '0) begin
               w_next = LOAD;
            end
         end
         LOAD: w_next = SEND;
         SEND: begin
            TX_enable = 1'b1;
            TX_data   = w_byte;
            w_next    = WAIT_ACK;
         end
         WAIT_ACK: begin
            if (tx_busy) begin
               w_next = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (!tx_busy) begin
               w_next = (r_idx == 2'd3) ? IDLE : SEND;
            end
         end
         default: w_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_word_tx_serializer.sv
// Bench for word_tx_serializer: a UART model answers strobes, a byte queue
// holds expected output, and strobes are checked against it on the falling edge.
module tb_word_tx_serializer;

   localparam int DEPTH = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         word_valid;
   logic [31:0]  word_data;
   logic         word_ready;
   logic         TX_enable;
   logic [7:0]   TX_data;
   logic         tx_busy;
   logic [$clog2(DEPTH):0] fifo_count;
   logic         busy;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] exp_q [$];
   int  ack_dly  = 0;
   int  busy_len = 4;
   int  b_cnt    = 0;
   int  d_cnt    = -1;
   int  gap      = 100;
   int  prev_cnt = 0;
   logic model_busy = 1'b0;
   logic hold_busy  = 1'b0;

   assign tx_busy = model_busy | hold_busy;

   always #5 clk = ~clk;

   word_tx_serializer #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .word_valid (word_valid),
      .word_data  (word_data),
      .word_ready (word_ready),
      .TX_enable  (TX_enable),
      .TX_data    (TX_data),
      .tx_busy    (tx_busy),
      .fifo_count (fifo_count),
      .busy       (busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard, strobe spacing and the UART model all step on the falling edge.
   always @(negedge clk) begin
      if (TX_enable) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_strobe: got %h, expected no strobe at %0t", TX_data, $time);
         end else begin
            chk("tx_byte", {24'h0, TX_data}, {24'h0, exp_q.pop_front()});
         end
         chk("strobe_while_uart_active", {31'h0, (b_cnt > 0 || d_cnt >= 0)}, 32'h0);
         chk("strobe_gap_ge3", {31'h0, (gap >= 3)}, 32'h1);
         gap = 1;
      end else begin
         gap++;
      end
      if (b_cnt > 0) b_cnt--;
      if (d_cnt > 0) d_cnt--;
      else if (d_cnt == 0) begin
         b_cnt = busy_len;
         d_cnt = -1;
      end
      if (TX_enable) begin
         if (ack_dly == 0) b_cnt = busy_len;
         else d_cnt = ack_dly;
      end
      model_busy = (b_cnt > 0);
      chk("fifo_count_le_depth", {31'h0, (int'(fifo_count) <= DEPTH)}, 32'h1);
      chk("fifo_count_step", {31'h0, (int'(fifo_count) - prev_cnt <= 1 && prev_cnt - int'(fifo_count) <= 1)}, 32'h1);
      prev_cnt = int'(fifo_count);
   end

   task automatic push_bytes(input logic [31:0] w, input logic acc,
                             input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
      word_valid = 1'b1;
      word_data  = w;
      chk("word_ready", {31'h0, word_ready}, {31'h0, acc});
      if (acc) begin
         exp_q.push_back(b0);
         exp_q.push_back(b1);
         exp_q.push_back(b2);
         exp_q.push_back(b3);
      end
      @(negedge clk);
      word_valid = 1'b0;
   endtask

   task automatic push(input logic [31:0] w, input logic acc);
      push_bytes(w, acc, w[7:0], w[15:8], w[23:16], w[31:24]);
   endtask

   task automatic wait_idle(input int budget);
      int k;
      for (k = 0; k < budget; k++) begin
         @(negedge clk);
         #1;
         if (!busy && !tx_busy && exp_q.size() == 0) break;
      end
      if (k == budget) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_idle_timeout: got busy=%b queued=%0d, expected idle", busy, exp_q.size());
      end
      chk("idle_fifo_count", {29'h0, fifo_count}, 32'h0);
      chk("idle_busy", {31'h0, busy}, 32'h0);
      chk("idle_queue_empty", exp_q.size(), 32'h0);
   endtask

   task automatic wait_uart_quiet(input int budget);
      int k;
      for (k = 0; k < budget; k++) begin
         if (!tx_busy && d_cnt < 0) break;
         @(negedge clk);
      end
      if (k == budget) begin
         n_checks++;
         n_fail++;
         $display("FAIL uart_quiet_timeout: got tx_busy=%b, expected 0", tx_busy);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_TX_enable"}, {31'h0, TX_enable}, 32'h0);
      chk({tag, "_TX_data"}, {24'h0, TX_data}, 32'h0);
      chk({tag, "_word_ready"}, {31'h0, word_ready}, 32'h1);
      chk({tag, "_fifo_count"}, {29'h0, fifo_count}, 32'h0);
      chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
   endtask

   typedef struct {
      logic [31:0] word;
      int          ack;
      int          blen;
      logic [7:0]  e0, e1, e2, e3;
   } vec_t;

   vec_t vecs [4];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no completion, expected finish before 1ms");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{32'hDDCCBBAA, 0, 10, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
      vecs[1] = '{32'h01234567, 0, 2,  8'h67, 8'h45, 8'h23, 8'h01};
      vecs[2] = '{32'h80FF7F00, 2, 3,  8'h00, 8'h7F, 8'hFF, 8'h80};
      vecs[3] = '{32'hA5C35A3C, 5, 4,  8'h3C, 8'h5A, 8'hC3, 8'hA5};

      // Reset with a push offered in the reset cycle; the push must vanish.
      rst        = 1'b1;
      word_valid = 1'b1;
      word_data  = 32'hCAFEF00D;
      @(negedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      word_valid = 1'b0;
      rst        = 1'b0;
      repeat (3) @(negedge clk);
      chk("post_reset_fifo_count", {29'h0, fifo_count}, 32'h0);
      chk("post_reset_busy", {31'h0, busy}, 32'h0);

      for (int i = 0; i < 4; i++) begin
         ack_dly  = vecs[i].ack;
         busy_len = vecs[i].blen;
         push_bytes(vecs[i].word, 1'b1, vecs[i].e0, vecs[i].e1, vecs[i].e2, vecs[i].e3);
         wait_idle(400);
      end

      // Fill with the UART held busy: first word loads, four queue, sixth drops.
      ack_dly   = 0;
      busy_len  = 2;
      hold_busy = 1'b1;
      for (int i = 0; i < 5; i++) push(32'h10203040 + 32'(i), 1'b1);
      push(32'hBADBAD00, 1'b0);
      chk("fill_fifo_count", {29'h0, fifo_count}, 32'd4);
      chk("fill_word_ready", {31'h0, word_ready}, 32'h0);
      chk("fill_bytes_left", exp_q.size(), 32'd19);
      hold_busy = 1'b0;
      wait_idle(1000);

      // Push lands on the LOAD cycle while two words are queued.
      busy_len = 3;
      push(32'hA0A1A2A3, 1'b1);
      push(32'hB0B1B2B3, 1'b1);
      chk("simul_load_count", {29'h0, fifo_count}, 32'd2);
      push(32'hC0C1C2C3, 1'b1);
      chk("simul_after_count", {29'h0, fifo_count}, 32'd2);
      wait_idle(1000);

      // Reset after the second byte of a word; remaining bytes must not appear.
      busy_len = 4;
      push(32'h11223344, 1'b1);
      begin
         int seen = 0;
         for (int k = 0; k < 200 && seen < 2; k++) begin
            @(negedge clk);
            #1;
            if (TX_enable) seen++;
         end
         chk("midreset_two_strobes", seen, 32'd2);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      exp_q.delete();
      word_valid = 1'b1;
      word_data  = 32'hDEADBEEF;
      @(negedge clk);
      check_reset_outputs("midreset");
      word_valid = 1'b0;
      rst        = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("midreset_after");
      wait_uart_quiet(100);
      push(32'h0000005A, 1'b1);
      wait_idle(400);

      // Stream twelve words so both pointers wrap three times.
      busy_len = 2;
      for (int i = 0; i < 12; i++) begin
         int k;
         for (k = 0; k < 200 && !word_ready; k++) @(negedge clk);
         chk("wrap_ready_wait", {31'h0, (k < 200)}, 32'h1);
         push(32'(i), 1'b1);
      end
      wait_idle(2000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/word_tx_serializer.md
WORD_TX_SERIALIZER -- requirements
Module: word_tx_serializer

Interface
- REQ-001 SHALL have parameter DEPTH, default 4, meaning word FIFO depth (power of two, >=2).
- REQ-002 SHALL have port clk  input  1  sole clock, all logic on rising edge.
- REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
- REQ-004 SHALL have port word_valid  input  1  producer offers word_data this cycle.
- REQ-005 SHALL have port word_data  input  32  word to transmit, typically a BRAM port-B readout.
- REQ-006 SHALL have port word_ready  output  1  FIFO can accept a word this cycle.
- REQ-007 SHALL have port TX_enable  output  1  one-cycle start strobe to UART transmitter.
- REQ-008 SHALL have port TX_data  output  8  byte to transmit, valid while TX_enable=1.
- REQ-009 SHALL have port tx_busy  input  1  UART transmitter shifting a byte.
- REQ-010 SHALL have port fifo_count  output  $clog2(DEPTH)+1  words currently queued, excluding the word being serialized.
- REQ-011 SHALL have port busy  output  1  serializer not in IDLE or FIFO non-empty.

Function
- REQ-012 SHALL push word_data into the FIFO on any cycle with word_valid=1 and word_ready=1.
- REQ-013 SHALL drive word_ready = (fifo_count < DEPTH), registered-state based; no same-cycle bypass when full.
- REQ-014 SHALL ignore word_valid while word_ready=0 (word dropped, no state change).
- REQ-015 SHALL wrap read/write pointers modulo DEPTH; fifo_count SHALL never exceed DEPTH or underflow.
- REQ-016 SHALL implement FSM states IDLE, LOAD, SEND, WAIT_ACK, WAIT_DONE.
- REQ-017 IDLE: if fifo_count>0 -> LOAD, else stay.
- REQ-018 LOAD: pop head word into a 32-bit shift register, set byte index 0, decrement fifo_count -> SEND.
- REQ-019 SEND: assert TX_enable for exactly one cycle with TX_data = shift register byte[index] -> WAIT_ACK.
- REQ-020 Byte order SHALL be little-endian: byte index 0 = word[7:0], index 3 = word[31:24].
- REQ-021 WAIT_ACK: stay until tx_busy=1, then -> WAIT_DONE; tx_busy already high on entry counts as ack.
- REQ-022 WAIT_DONE: stay until tx_busy=0; then if index=3 -> IDLE, else index+1 -> SEND.
- REQ-023 Simultaneous push and LOAD pop in one cycle SHALL leave fifo_count unchanged and keep both words correctly ordered.
- REQ-024 TX_enable SHALL be 0 in every state except SEND; TX_data SHALL hold its last value outside SEND.
- REQ-025 Minimum spacing between consecutive TX_enable strobes SHALL be 3 cycles (SEND, WAIT_ACK, WAIT_DONE), longer per tx_busy.
- REQ-026 A word SHALL be fully emitted as 4 strobes before the next word is loaded; words SHALL leave in push order.

Reset
- REQ-027 rst=1 at a clock edge SHALL empty the FIFO, zero the pointers and fifo_count, clear the byte index, and force IDLE.
- REQ-028 During and after reset, outputs SHALL be TX_enable=0, TX_data=8'h00, word_ready=1, fifo_count=0, busy=0.
- REQ-029 Reset mid-word SHALL abandon remaining bytes with no further strobe; a byte already started in the UART is not recalled.
- REQ-030 A push presented in the reset cycle SHALL be discarded.

Verification
- REQ-031 Single word: push 32'hDDCCBBAA, UART model busy 10 cycles per byte -> strobes carry AA, BB, CC, DD in order, then busy=0, fifo_count=0.
- REQ-032 Fill: push 5 words back-to-back with DEPTH=4 and tx_busy held high -> first word loaded, 4 queued, word_ready=0, 6th push dropped; after release, 20 bytes emitted in order.
- REQ-033 Simultaneous: push on the exact LOAD cycle with fifo_count=2 -> fifo_count stays 2, and the byte stream shows no loss or reorder.
- REQ-034 Slow ack: tx_busy rises 5 cycles after TX_enable -> FSM holds WAIT_ACK with no repeat strobe; next strobe only after tx_busy falls.
- REQ-035 Reset mid-word: assert rst after the 2nd byte strobe of 32'h11223344 -> no strobe for 22/11, outputs at reset values, new push 32'h0000005A then emits 5A,00,00,00.
- REQ-036 Wrap: stream 12 words 32'h0..32'hB with DEPTH=4 -> 48 bytes, correct order, pointers wrap three times, no spurious fifo_count values.
